// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage of the 5-stage MIPS pipeline.
// It owns the PC and fetches from instruction memory over a variable-latency
// req/ack handshake. It also loads the IF/ID pipeline register, which it
// freezes on hazard_detected and flushes or redirects on Br_Taken.
//
// Handshake: imem_req is the valid and imem_ack is the ready. Once raised,
// imem_req and imem_addr hold until the cycle in which imem_ack=1. That cycle
// completes the transfer, and imem_rdata is sampled at its rising edge.
// imem_ack is ignored while imem_req=0. Stalls and redirects never withdraw
// an outstanding request. A redirect that arrives mid-request marks the
// in-flight data for squashing instead.
module if_fetch_unit #(
    parameter int                  WORD_LEN = 32,
    parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hazard_detected,
    input  logic                Br_Taken,
    input  logic [WORD_LEN-1:0] br_addr,
    output logic                imem_req,
    output logic [WORD_LEN-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [WORD_LEN-1:0] imem_rdata,
    output logic [WORD_LEN-1:0] PC_IF_ID,
    output logic [WORD_LEN-1:0] inst_IF_ID,
    output logic                valid_IF_ID,
    output logic                dbg_state
);

    // REQ: a fetch is on the bus. BUF: one fetched word is parked while ID stalls.
    localparam logic [0:0] ST_REQ = 1'b0;
    localparam logic [0:0] ST_BUF = 1'b1;

    localparam logic [WORD_LEN-1:0] PC_STEP = WORD_LEN'(4);

    logic [0:0]          state;
    logic [WORD_LEN-1:0] pc;
    logic [WORD_LEN-1:0] pc_plus4;
    logic [WORD_LEN-1:0] buf_inst;
    logic [WORD_LEN-1:0] buf_pc4;
    logic                squash;
    logic [WORD_LEN-1:0] redir;
    logic                br_eff;

    // A hazard takes priority over a branch; the branch is re-evaluated later.
    assign br_eff   = Br_Taken & ~hazard_detected;
    assign pc_plus4 = pc + PC_STEP;

    // Request is forced low during reset; no request is made while a word is buffered.
    assign imem_req  = (state == ST_REQ) & ~rst;
    assign imem_addr = pc;
    assign dbg_state = state[0];

    // PC, fetch FSM, skid buffer, squash tracking and the IF/ID register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_REQ;
            pc          <= RESET_PC;
            buf_inst    <= '0;
            buf_pc4     <= '0;
            squash      <= 1'b0;
            redir       <= '0;
            PC_IF_ID    <= '0;
            inst_IF_ID  <= '0;
            valid_IF_ID <= 1'b0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (imem_ack) begin
                        if (squash || br_eff) begin
                            // Data belongs to the wrong path: drop it and go to the target.
                            pc     <= br_eff ? br_addr : redir;
                            squash <= 1'b0;
                            if (br_eff || !hazard_detected) begin
                                valid_IF_ID <= 1'b0;
                            end
                        end else if (hazard_detected) begin
                            // ID is frozen, so park the word until the stall clears.
                            buf_inst <= imem_rdata;
                            buf_pc4  <= pc_plus4;
                            pc       <= pc_plus4;
                            state    <= ST_BUF;
                        end else begin
                            PC_IF_ID    <= pc_plus4;
                            inst_IF_ID  <= imem_rdata;
                            valid_IF_ID <= 1'b1;
                            pc          <= pc_plus4;
                        end
                    end else if (br_eff) begin
                        // Cannot withdraw the request; remember to discard its data.
                        squash      <= 1'b1;
                        redir       <= br_addr;
                        valid_IF_ID <= 1'b0;
                    end else if (!hazard_detected) begin
                        valid_IF_ID <= 1'b0;
                    end
                end
                ST_BUF: begin
                    if (br_eff) begin
                        pc          <= br_addr;
                        valid_IF_ID <= 1'b0;
                        state       <= ST_REQ;
                    end else if (!hazard_detected) begin
                        PC_IF_ID    <= buf_pc4;
                        inst_IF_ID  <= buf_inst;
                        valid_IF_ID <= 1'b1;
                        state       <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed vector table for the fetch-stage corner cases,
// then randomized memory latency / hazard / branch traffic checked against a
// transaction-level reference model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hazard_detected = 1'b0;
    logic        Br_Taken = 1'b0;
    logic [31:0] br_addr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] PC_IF_ID;
    logic [31:0] inst_IF_ID;
    logic        valid_IF_ID;
    logic        dbg_state;

    int checks = 0;
    int errors = 0;

    if_fetch_unit #(.WORD_LEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .hazard_detected(hazard_detected),
        .Br_Taken(Br_Taken), .br_addr(br_addr), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .PC_IF_ID(PC_IF_ID), .inst_IF_ID(inst_IF_ID),
        .valid_IF_ID(valid_IF_ID), .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, hz, br;
        logic [31:0] ba;
        logic        ack;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr, e_pc, e_inst;
        logic        e_valid;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic hz, input logic br, input logic [31:0] ba,
                       input logic ack, input logic [31:0] rd, input logic e_req,
                       input logic [31:0] e_addr, input logic [31:0] e_pc,
                       input logic [31:0] e_inst, input logic e_valid);
        vec_t v;
        v.rst = r; v.hz = hz; v.br = br; v.ba = ba; v.ack = ack; v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc; v.e_inst = e_inst; v.e_valid = e_valid;
        vecs.push_back(v);
    endtask

    // Driver: apply one cycle of inputs (called at posedge+1).
    task automatic drive(input logic r, input logic hz, input logic br, input logic [31:0] ba,
                         input logic ack, input logic [31:0] rd);
        rst = r; hazard_detected = hz; Br_Taken = br; br_addr = ba;
        imem_ack = ack; imem_rdata = rd;
    endtask

    // Reference model: IF/ID contents, PC, at most one parked word, pending redirect.
    logic [31:0] m_pc, m_if_pc, m_if_inst, m_redir;
    logic        m_if_valid, m_squash;
    logic [63:0] m_buf[$];

    function automatic void model_reset();
        m_pc = 32'h0; m_if_pc = '0; m_if_inst = '0; m_if_valid = 1'b0;
        m_squash = 1'b0; m_redir = '0; m_buf.delete();
    endfunction

    function automatic void model_step(input logic r, input logic hz, input logic br,
                                       input logic [31:0] ba, input logic ack,
                                       input logic [31:0] rd);
        logic taken;
        logic [63:0] e;
        taken = br && !hz;
        if (r) begin
            model_reset();
        end else if (m_buf.size() != 0) begin
            if (taken) begin
                m_buf.delete(); m_pc = ba; m_if_valid = 1'b0;
            end else if (!hz) begin
                e = m_buf.pop_front();
                m_if_inst = e[63:32]; m_if_pc = e[31:0]; m_if_valid = 1'b1;
            end
        end else if (ack) begin
            if (m_squash || taken) begin
                m_pc = taken ? ba : m_redir;
                m_squash = 1'b0;
                if (taken || !hz) m_if_valid = 1'b0;
            end else if (hz) begin
                m_buf.push_back({rd, m_pc + 32'd4});
                m_pc = m_pc + 32'd4;
            end else begin
                m_if_pc = m_pc + 32'd4; m_if_inst = rd; m_if_valid = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end else if (taken) begin
            m_squash = 1'b1; m_redir = ba; m_if_valid = 1'b0;
        end else if (!hz) begin
            m_if_valid = 1'b0;
        end
    endfunction

    // Random-phase memory responder state.
    logic        mem_busy;
    int          mem_lat;
    logic [31:0] mem_addr;

    initial begin
        // Directed table: expected outputs are those seen just after the edge.
        add(1,0,0,0,0,0,            0,32'h0,32'h0,32'h0,0);
        add(1,0,0,0,0,0,            0,32'h0,32'h0,32'h0,0);
        // zero-wait streaming
        add(0,0,0,0,1,32'hA000,     1,32'h4,32'h4,32'hA000,1);
        add(0,0,0,0,1,32'hA004,     1,32'h8,32'h8,32'hA004,1);
        add(0,0,0,0,1,32'hA008,     1,32'hC,32'hC,32'hA008,1);
        // ack delayed 2 cycles on first fetch
        add(1,0,0,0,0,0,            0,32'h0,32'h0,32'h0,0);
        add(0,0,0,0,0,0,            1,32'h0,32'h0,32'h0,0);
        add(0,0,0,0,0,0,            1,32'h0,32'h0,32'h0,0);
        add(0,0,0,0,1,32'hA000,     1,32'h4,32'h4,32'hA000,1);
        // hazard spanning the ack at 0x8
        add(0,0,0,0,1,32'hA004,     1,32'h8,32'h8,32'hA004,1);
        add(0,1,0,0,1,32'hA008,     0,32'hC,32'h8,32'hA004,1);
        add(0,1,0,0,0,0,            0,32'hC,32'h8,32'hA004,1);
        add(0,1,0,0,0,0,            0,32'hC,32'h8,32'hA004,1);
        add(0,0,0,0,0,0,            1,32'hC,32'hC,32'hA008,1);
        add(0,0,0,0,1,32'hA00C,     1,32'h10,32'h10,32'hA00C,1);
        // branch while fetch at 0x10 awaits ack
        add(0,0,1,32'h40,0,0,       1,32'h10,32'h10,32'hA00C,0);
        add(0,0,0,0,0,0,            1,32'h10,32'h10,32'hA00C,0);
        add(0,0,0,0,1,32'hA010,     1,32'h40,32'h10,32'hA00C,0);
        add(0,0,0,0,1,32'hA040,     1,32'h44,32'h44,32'hA040,1);
        // branch with hazard is ignored, then taken next cycle
        add(0,1,1,32'h80,0,0,       1,32'h44,32'h44,32'hA040,1);
        add(0,0,1,32'h80,1,32'hA044,1,32'h80,32'h44,32'hA040,0);
        add(0,0,0,0,1,32'hA080,     1,32'h84,32'h84,32'hA080,1);
        // branch while a word is parked drops it
        add(0,1,0,0,1,32'hA084,     0,32'h88,32'h84,32'hA080,1);
        add(0,0,1,32'hC0,0,0,       1,32'hC0,32'h84,32'hA080,0);
        add(0,0,0,0,1,32'hA0C0,     1,32'hC4,32'hC4,32'hA0C0,1);
        // reset with a request outstanding
        add(0,0,0,0,0,0,            1,32'hC4,32'hC4,32'hA0C0,0);
        add(1,0,0,0,0,0,            0,32'h0,32'h0,32'h0,0);
        add(0,0,0,0,0,0,            1,32'h0,32'h0,32'h0,0);
        add(0,0,0,0,1,32'hA000,     1,32'h4,32'h4,32'hA000,1);
        // PC wrap at the top of the address space
        add(0,0,1,32'hFFFF_FFFC,1,32'hA004, 1,32'hFFFF_FFFC,32'h4,32'hA000,0);
        add(0,0,0,0,1,32'h1234,     1,32'h0,32'h0,32'h1234,1);

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].hz, vecs[i].br, vecs[i].ba, vecs[i].ack, vecs[i].rd);
            @(posedge clk); #1;
            chk($sformatf("vec%0d imem_req", i),    {31'b0, imem_req},    {31'b0, vecs[i].e_req});
            chk($sformatf("vec%0d imem_addr", i),   imem_addr,            vecs[i].e_addr);
            chk($sformatf("vec%0d PC_IF_ID", i),    PC_IF_ID,             vecs[i].e_pc);
            chk($sformatf("vec%0d inst_IF_ID", i),  inst_IF_ID,           vecs[i].e_inst);
            chk($sformatf("vec%0d valid_IF_ID", i), {31'b0, valid_IF_ID}, {31'b0, vecs[i].e_valid});
        end

        // Randomized phase.
        drive(1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        model_reset();
        mem_busy = 1'b0; mem_lat = 0; mem_addr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        r, hz, br, ack;
            logic [31:0] ba, rd;
            r  = ($urandom_range(0, 99) < 2);
            hz = ($urandom_range(0, 99) < 30);
            br = ($urandom_range(0, 99) < 15);
            ba = {$urandom_range(0, 32'h3FFF), 2'b00};
            if (cyc > 2900) ba = 32'hFFFF_FFF0;
            ack = 1'b0;
            rd  = $urandom();
            if (r) begin
                mem_busy = 1'b0;
            end else if (imem_req) begin
                if (!mem_busy) begin
                    mem_busy = 1'b1;
                    mem_lat  = $urandom_range(0, 3);
                    mem_addr = imem_addr;
                end else begin
                    chk("rand addr_stable", imem_addr, mem_addr);
                end
                if (mem_lat == 0) begin
                    ack = 1'b1;
                    mem_busy = 1'b0;
                end else begin
                    mem_lat--;
                end
            end
            drive(r, hz, br, ba, ack, rd);
            model_step(r, hz, br, ba, ack, rd);
            @(posedge clk); #1;
            chk("rand imem_req",    {31'b0, imem_req},    {31'b0, (!rst && m_buf.size() == 0)});
            chk("rand imem_addr",   imem_addr,            m_pc);
            chk("rand PC_IF_ID",    PC_IF_ID,             m_if_pc);
            chk("rand inst_IF_ID",  inst_IF_ID,           m_if_inst);
            chk("rand valid_IF_ID", {31'b0, valid_IF_ID}, {31'b0, m_if_valid});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the 5-stage MIPS pipeline. It sits at the consuming end of the hazard/branch control path. It owns the PC and issues requests to instruction memory over a variable-latency req/ack handshake. It loads the IF/ID pipeline register and obeys `hazard_detected` (freeze) and `Br_Taken` (redirect/flush) from the ID stage.

## Interface
Parameters:
- `WORD_LEN`, 32, data/address width
- `RESET_PC`, 0, first fetch address after reset

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `hazard_detected`  in  1  ID stall request; freezes IF/ID and PC advance
- `Br_Taken`  in  1  branch resolved taken in ID
- `br_addr`  in  WORD_LEN  redirect target, valid when `Br_Taken`=1
- `imem_req`  out  1  fetch request
- `imem_addr`  out  WORD_LEN  fetch address; stable while `imem_req`=1 and no ack
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle; ignored when `imem_req`=0
- `imem_rdata`  in  WORD_LEN  fetched instruction
- `PC_IF_ID`  out  WORD_LEN  fetched PC+4 (registered)
- `inst_IF_ID`  out  WORD_LEN  fetched instruction (registered)
- `valid_IF_ID`  out  1  IF/ID holds a real instruction; 0 = bubble

## Operation
- Registers: `pc`, state {REQ, BUF}, 1-entry buffer {inst, pc+4}, `squash` flag, `redir` target.
- Effective branch: `br_eff = Br_Taken & ~hazard_detected`. When both are high, hazard wins. The branch is ignored that cycle and is re-evaluated once the hazard clears.
- REQ: `imem_req`=1, `imem_addr`=`pc`.
  - ack & (`squash` | `br_eff`): discard data; `pc`<=`br_eff` ? `br_addr` : `redir`; clear `squash`; IF/ID `valid`<=0 if `br_eff`, else hold when hazard, else 0; stay REQ.
  - ack & `hazard_detected`: buffer {rdata, pc+4}; `pc`<=pc+4; IF/ID held; go BUF.
  - ack, no stall, no branch: IF/ID<={pc+4, rdata, 1}; `pc`<=pc+4; stay REQ. Back-to-back requests are allowed.
  - no ack & `br_eff`: `squash`<=1, `redir`<=`br_addr`, IF/ID `valid`<=0; address held.
  - no ack & `hazard_detected`: IF/ID held.
  - no ack otherwise: IF/ID `valid`<=0 (bubble).
- BUF: `imem_req`=0.
  - `br_eff`: drop buffer; `pc`<=`br_addr`; IF/ID `valid`<=0; go REQ.
  - `hazard_detected`: hold everything.
  - otherwise: IF/ID<=buffer with `valid`=1; go REQ.
- PC arithmetic: +4, modulo 2^WORD_LEN. The wrap from 0xFFFFFFFC to 0 is silent.
- While stalled, PC_IF_ID, inst_IF_ID and valid_IF_ID all hold.

## Timing
- Reset values: `pc`=RESET_PC, state=REQ, `squash`=0, `redir`=0, buffer=0. `PC_IF_ID`=0, `inst_IF_ID`=0, `valid_IF_ID`=0.
- `imem_req` is forced to 0 while `rst`=1. First request (addr RESET_PC) goes out in the first cycle after `rst` falls.
- Zero-wait memory (ack in the same cycle as req): 1-cycle latency from request to IF/ID and 1 instruction/cycle throughput.
- N-cycle ack delay: N bubbles into IF/ID.
- Handshake rule: once raised, `imem_req` and `imem_addr` do not change until the ack cycle. Redirect and stall never withdraw an outstanding request.
- Reset mid-request aborts the request. The memory is reset by the same `rst`.
- No request is issued in BUF, so at most one instruction is outstanding or buffered.

## Test plan
- Reset, then ack every cycle with rdata=addr|0xA000: `valid_IF_ID`=1 and PC_IF_ID=4, 8, 12 on consecutive cycles; inst=0xA000, 0xA004, 0xA008.
- Ack delayed 2 cycles on first fetch: `imem_addr`=0 stable for 3 cycles and `valid_IF_ID`=0 throughout. Next cycle PC_IF_ID=4 with valid=1.
- `hazard_detected`=1 for 3 cycles, spanning an ack at addr 0x8: IF/ID holds the prior instruction, `imem_req`=0 after the ack. The cycle after the hazard drops, IF/ID shows PC_IF_ID=0xC, then the fetch of 0xC issues.
- `Br_Taken`=1, `br_addr`=0x40 while the fetch at 0x10 awaits ack (ack 2 cycles later): `imem_addr`=0x10 held until ack, data discarded with `valid_IF_ID`=0. The next request is to 0x40, and its instruction lands with PC_IF_ID=0x44.
- `Br_Taken`=1 and `hazard_detected`=1 in the same cycle: no redirect and IF/ID held. With `Br_Taken`=1 on the following cycle and hazard=0, the redirect takes effect.
- `rst` asserted while a request is outstanding: next cycle all outputs at reset values and `imem_req`=0. After release, the request goes to RESET_PC.
